pixel_write_sched: RTL
======================

PIXEL_WRITE_SCHED -- requirements
Module: pixel_write_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, the VRAM 32-bit word address width.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_nrst  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports in_valid in 1, in_ready out 1: pixel-pair request handshake.
REQ-005 SHALL have ports in_addr in ADDR_W, in_mask in 2 (bit0=L, bit1=R write enable), in_needBG in 1 (blend or mask-check required).
REQ-006 SHALL have ports bg_req out 1, bg_addr out ADDR_W, bg_ack in 1: background read command.
REQ-007 SHALL have ports bg_dvalid in 1, bg_data in 32: background read return.
REQ-008 SHALL have ports bg_word out 32 (registered BG pair to compute datapath) and cmp_data in 32 (compute datapath write32 result, combinational from bg_word and the latched pair).
REQ-009 SHALL have ports wr_valid out 1, wr_ready in 1, wr_addr out ADDR_W, wr_data out 32, wr_mask out 2: write FIFO push.
REQ-010 SHALL have ports flush in 1 (invalidate BG cache) and busy out 1 (state != IDLE).

Function
REQ-011 SHALL implement states IDLE, BGREQ, BGWAIT, COMPUTE, WRITE.
REQ-012 IDLE: in_ready=1; on in_valid, latch addr/mask/needBG; go BGREQ if needBG and no cache hit, else COMPUTE.
REQ-013 in_mask==0 with in_valid SHALL be accepted and dropped (stay IDLE, no bg_req, no wr_valid).
REQ-014 BGREQ: bg_req=1, bg_addr=latched addr, held stable until bg_ack; on bg_ack go BGWAIT.
REQ-015 BGWAIT: on bg_dvalid capture bg_data into bg_word, go COMPUTE; bg_dvalid in other states SHALL be ignored.
REQ-016 When needBG=0, bg_word SHALL be forced to 0 on entering COMPUTE.
REQ-017 COMPUTE: one cycle; capture cmp_data into wr_data, go WRITE.
REQ-018 WRITE: wr_valid=1 with wr_addr/wr_data/wr_mask stable until wr_ready; on wr_ready go IDLE.
REQ-019 Latency, no-BG path: in_valid accepted cycle T, wr_valid first high T+2; next in_ready high the cycle after wr_ready.
REQ-020 Latency, BG path: bg_req at T+1; wr_valid two cycles after bg_dvalid.
REQ-021 in_ready SHALL be 0 in every state other than IDLE; at most one pair in flight.
REQ-022 wr_valid, bg_req SHALL never be high together.

Reset
REQ-023 On i_nrst low: state=IDLE, in_ready=1 after release, bg_req=0, wr_valid=0, busy=0, bg_word=0, wr_data=0, wr_addr=0, wr_mask=0, cache invalid; effective immediately, including mid-transaction (pending read data discarded).

Configuration
REQ-024 Macro PIXEL_WRITE_SCHED_BGCACHE_EN SHALL compile in a one-entry BG cache.
REQ-025 With it: on each wr_ready, store wr_addr and merged word (written halves from wr_data, unwritten halves from bg_word); in IDLE, needBG with valid cache and in_addr==cached addr SHALL load bg_word from cache and go straight to COMPUTE (no bg_req); flush or reset invalidates; flush in same cycle as a hit wins (miss).
REQ-026 Without it: every needBG request issues bg_req; flush is ignored.

Verification
REQ-027 needBG=0, addr=0x00010, mask=2'b11, cmp_data=0x7FFF0421, wr_ready=1 -> wr_valid at T+2 with wr_addr=0x00010, wr_data=0x7FFF0421, no bg_req.
REQ-028 needBG=1, addr=0x00020, bg_ack delayed 3 cycles, bg_data=0x12345678 -> bg_req held 3 cycles, bg_word=0x12345678 in COMPUTE, wr_valid two cycles after bg_dvalid.
REQ-029 wr_ready low 5 cycles in WRITE -> wr_* stable, in_ready=0 throughout, second in_valid accepted only after wr_ready.
REQ-030 i_nrst asserted in BGWAIT then released, late bg_dvalid arrives -> outputs at reset values, no wr_valid, in_ready=1.
REQ-031 BGCACHE_EN: write addr 0x00030 mask=2'b01 data=0xAAAA5555 over bg 0x11112222, then needBG same addr -> no bg_req, bg_word=0x11115555; repeat with flush in accept cycle -> bg_req issued.
REQ-032 in_mask=0 request -> no bg_req, no wr_valid, in_ready stays 1.

Source files
------------

// File: rtl/pixel_write_sched_if.sv
// pixel_write_sched_if: pixel-pair request, background read, compute and write-FIFO signals of the scheduler.
interface pixel_write_sched_if #(parameter int ADDR_W = 18);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [1:0]        in_mask;
  logic              in_needBG;
  logic              bg_req;
  logic [ADDR_W-1:0] bg_addr;
  logic              bg_ack;
  logic              bg_dvalid;
  logic [31:0]       bg_data;
  logic [31:0]       bg_word;
  logic [31:0]       cmp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [1:0]        wr_mask;
  logic              flush;
  logic              busy;
  modport master (
    input  in_valid, in_addr, in_mask, in_needBG, bg_ack, bg_dvalid, bg_data, cmp_data, wr_ready, flush,
    output in_ready, bg_req, bg_addr, bg_word, wr_valid, wr_addr, wr_data, wr_mask, busy
  );
  modport slave (
    output in_valid, in_addr, in_mask, in_needBG, bg_ack, bg_dvalid, bg_data, cmp_data, wr_ready, flush,
    input  in_ready, bg_req, bg_addr, bg_word, wr_valid, wr_addr, wr_data, wr_mask, busy
  );
endinterface

// File: rtl/pixel_write_sched.sv
// pixel_write_sched: one-pair-in-flight pixel write scheduler (optional background read, compute, write push).
// Define PIXEL_WRITE_SCHED_BGCACHE_EN to add a one-entry cache of the last written background word.
module pixel_write_sched #(
  parameter int ADDR_W = 18
) (
  input logic clk,
  input logic i_nrst,
  pixel_write_sched_if.master p
);
  typedef enum logic [2:0] {IDLE, BGREQ, BGWAIT, COMPUTE, WRITE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mask_q, mask_d;
  logic [31:0]       bg_word_q, bg_word_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              hit;
  logic [31:0]       cache_word;
`ifdef PIXEL_WRITE_SCHED_BGCACHE_EN
  logic              cvalid_q, cvalid_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [31:0]       cdata_q, cdata_d;
  logic              store;
  assign hit        = cvalid_q && p.in_addr == caddr_q && !p.flush;
  assign cache_word = cdata_q;
  assign store      = state_q == WRITE && p.wr_ready;
  // Unwritten halves keep the background value so the entry mirrors VRAM after the write.
  always_comb begin
    cvalid_d = p.flush ? 1'b0 : (store ? 1'b1 : cvalid_q);
    caddr_d  = store ? addr_q : caddr_q;
    cdata_d  = store ? {mask_q[1] ? wr_data_q[31:16] : bg_word_q[31:16],
                        mask_q[0] ? wr_data_q[15:0]  : bg_word_q[15:0]} : cdata_q;
  end
  always_ff @(posedge clk or negedge i_nrst)
    if (!i_nrst) begin
      cvalid_q <= 1'b0;
      caddr_q  <= '0;
      cdata_q  <= '0;
    end else begin
      cvalid_q <= cvalid_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
    end
`else
  assign hit        = 1'b0;
  assign cache_word = '0;
`endif
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    bg_word_d = bg_word_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE:
        if (p.in_valid && p.in_mask != 2'b00) begin
          addr_d    = p.in_addr;
          mask_d    = p.in_mask;
          state_d   = (p.in_needBG && !hit) ? BGREQ : COMPUTE;
          bg_word_d = !p.in_needBG ? '0 : (hit ? cache_word : bg_word_q);
        end
      BGREQ:   state_d = p.bg_ack ? BGWAIT : BGREQ;
      BGWAIT:
        if (p.bg_dvalid) begin
          bg_word_d = p.bg_data;
          state_d   = COMPUTE;
        end
      COMPUTE: begin
        wr_data_d = p.cmp_data;
        state_d   = WRITE;
      end
      WRITE:   state_d = p.wr_ready ? IDLE : WRITE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge i_nrst)
    if (!i_nrst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      bg_word_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      bg_word_q <= bg_word_d;
      wr_data_q <= wr_data_d;
    end
  assign p.in_ready = state_q == IDLE;
  assign p.busy     = state_q != IDLE;
  assign p.bg_req   = state_q == BGREQ;
  assign p.wr_valid = state_q == WRITE;
  assign p.bg_addr  = addr_q;
  assign p.wr_addr  = addr_q;
  assign p.wr_mask  = mask_q;
  assign p.bg_word  = bg_word_q;
  assign p.wr_data  = wr_data_q;
endmodule
